// File: rtl/dac_sample_pacer_if.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_pacer_if
// Description : Sample-push and DAC-request signals of the DAC sample pacer.
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_sample_pacer_if;
    logic [15:0] input_sample;
    logic        input_valid;
    logic        input_ready;
    logic [11:0] output_sample;
    logic        output_send_n;
    logic        dac_busy;

    // master = the pacer; slave = mixer plus DAC controller around it
    modport master (
        input  input_sample,
        input  input_valid,
        input  dac_busy,
        output input_ready,
        output output_sample,
        output output_send_n
    );

    modport slave (
        output input_sample,
        output input_valid,
        output dac_busy,
        input  input_ready,
        input  output_sample,
        input  output_send_n
    );
endinterface
`default_nettype wire

// File: rtl/dac_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_pacer
// Description : Buffers signed 16-bit samples and releases one 12-bit
//               offset-binary sample per output slot to the SPI DAC controller.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_pacer #(
    parameter int SAMPLE_DIVIDE     = 2268,
    parameter int FIFO_ADDR_BITS    = 4,
    parameter int HANDSHAKE_TIMEOUT = 4096
) (
    input  wire                        clock_50Mhz,
    input  wire                        reset,
    input  wire                        enable,
    dac_sample_pacer_if.master         bus,
    output logic [FIFO_ADDR_BITS:0]    fifo_level,
    output logic                       sample_tick,
    output logic [15:0]                underrun_count,
    output logic                       late_error
);

    localparam int c_FIFO_DEPTH = 2 ** FIFO_ADDR_BITS;
    localparam int c_LVL_W      = FIFO_ADDR_BITS + 1;
    localparam int c_CNT_W      = $clog2(SAMPLE_DIVIDE);
    localparam int c_TO_W       = $clog2(HANDSHAKE_TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_SLOT_LAST  = c_CNT_W'(SAMPLE_DIVIDE - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST    = c_TO_W'(HANDSHAKE_TIMEOUT - 1);
    localparam logic [c_LVL_W-1:0] c_LEVEL_FULL = c_LVL_W'(c_FIFO_DEPTH);
    localparam logic [11:0]        c_MIDSCALE   = 12'h800;
    localparam logic [15:0]        c_UNDER_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQUEST   = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0]        r_slot_cnt_q, w_slot_cnt_d;
    logic                      r_busy_meta_q;
    logic                      r_busy_s_q;
    state_t                    r_state_q, w_state_d;
    logic [c_TO_W-1:0]         r_to_cnt_q, w_to_cnt_d;
    logic                      r_send_n_q, w_send_n_d;
    logic [11:0]               r_sample_q, w_sample_d;
    logic [15:0]               r_underrun_q, w_underrun_d;
    logic                      r_late_q, w_late_d;
    logic [FIFO_ADDR_BITS-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [FIFO_ADDR_BITS-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_LVL_W-1:0]        r_level_q, w_level_d;
    logic [15:0]               r_mem_q [c_FIFO_DEPTH];

    logic        w_tick;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_pop;
    logic [15:0] w_head;
    logic [11:0] w_head_conv;
    logic        w_unused_lsbs;

    // ------------------------------------------------------------------
    // Slot pacing
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_cnt_d = r_slot_cnt_q;
        if (!enable || (r_slot_cnt_q == c_SLOT_LAST)) begin
            w_slot_cnt_d = '0;
        end else begin
            w_slot_cnt_d = r_slot_cnt_q + 1'b1;
        end
    end

    assign w_tick = enable && (r_slot_cnt_q == c_SLOT_LAST);

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    assign w_fifo_full  = (r_level_q == c_LEVEL_FULL);
    assign w_fifo_empty = (r_level_q == '0);
    assign w_push       = bus.input_valid && !w_fifo_full;
    assign w_head       = r_mem_q[r_rd_ptr_q];

    // Offset binary: flip the sign bit, keep the 11 next-most-significant bits
    assign w_head_conv   = {~w_head[15], w_head[14:4]};
    assign w_unused_lsbs = ^w_head[3:0];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   w_level_d = r_level_q + 1'b1;
            2'b01:   w_level_d = r_level_q - 1'b1;
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge clock_50Mhz) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= bus.input_sample;
        end
    end

    // ------------------------------------------------------------------
    // Request / busy handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_send_n_d   = r_send_n_q;
        w_to_cnt_d   = r_to_cnt_q;
        w_sample_d   = r_sample_q;
        w_underrun_d = r_underrun_q;
        w_late_d     = r_late_q;
        w_pop        = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_send_n_d = 1'b1;
                w_to_cnt_d = '0;
                if (w_tick) begin
                    if (r_busy_s_q) begin
                        w_late_d = 1'b1;
                    end else begin
                        // An empty FIFO re-sends the previous level
                        if (!w_fifo_empty) begin
                            w_pop      = 1'b1;
                            w_sample_d = w_head_conv;
                        end else if (r_underrun_q != c_UNDER_MAX) begin
                            w_underrun_d = r_underrun_q + 16'd1;
                        end
                        w_send_n_d = 1'b0;
                        w_state_d  = S_REQUEST;
                    end
                end
            end

            S_REQUEST: begin
                if (w_tick) begin
                    w_late_d = 1'b1;
                end
                if (r_busy_s_q) begin
                    w_send_n_d = 1'b1;
                    w_state_d  = S_WAIT_DONE;
                end else if (r_to_cnt_q == c_TO_LAST) begin
                    w_send_n_d = 1'b1;
                    w_late_d   = 1'b1;
                    w_state_d  = S_IDLE;
                end else begin
                    w_to_cnt_d = r_to_cnt_q + 1'b1;
                end
            end

            S_WAIT_DONE: begin
                w_send_n_d = 1'b1;
                if (w_tick) begin
                    w_late_d = 1'b1;
                end
                if (!r_busy_s_q) begin
                    w_state_d = S_IDLE;
                end
            end

            default: begin
                w_send_n_d = 1'b1;
                w_state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            r_slot_cnt_q  <= '0;
            r_busy_meta_q <= 1'b0;
            r_busy_s_q    <= 1'b0;
            r_state_q     <= S_IDLE;
            r_to_cnt_q    <= '0;
            r_send_n_q    <= 1'b1;
            r_sample_q    <= c_MIDSCALE;
            r_underrun_q  <= '0;
            r_late_q      <= 1'b0;
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_level_q     <= '0;
        end else begin
            r_slot_cnt_q  <= w_slot_cnt_d;
            r_busy_meta_q <= bus.dac_busy;
            r_busy_s_q    <= r_busy_meta_q;
            r_state_q     <= w_state_d;
            r_to_cnt_q    <= w_to_cnt_d;
            r_send_n_q    <= w_send_n_d;
            r_sample_q    <= w_sample_d;
            r_underrun_q  <= w_underrun_d;
            r_late_q      <= w_late_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_level_q     <= w_level_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.input_ready   = !w_fifo_full;
    assign bus.output_sample = r_sample_q;
    assign bus.output_send_n = r_send_n_q;
    assign fifo_level        = r_level_q;
    assign sample_tick       = w_tick;
    assign underrun_count    = r_underrun_q;
    assign late_error        = r_late_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_sample_pacer
// Description : Self-checking bench for dac_sample_pacer with a DAC busy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_sample_pacer;

    localparam int SAMPLE_DIVIDE     = 2268;
    localparam int HANDSHAKE_TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [4:0]  fifo_level;
    logic        sample_tick;
    logic [15:0] underrun_count;
    logic        late_error;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned cycle_no = 0;

    dac_sample_pacer_if pif ();

    dac_sample_pacer #(
        .SAMPLE_DIVIDE     (SAMPLE_DIVIDE),
        .FIFO_ADDR_BITS    (4),
        .HANDSHAKE_TIMEOUT (HANDSHAKE_TIMEOUT)
    ) dut (
        .clock_50Mhz    (clk),
        .reset          (rst),
        .enable         (enable),
        .bus            (pif.master),
        .fifo_level     (fifo_level),
        .sample_tick    (sample_tick),
        .underrun_count (underrun_count),
        .late_error     (late_error)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    // DAC controller model: busy rises 40 cycles after a send request, lasts dac_dur
    bit dac_clear = 1'b1;
    bit dac_never = 1'b0;
    int dac_dur   = 1500;
    int dac_delay = 0;
    int dac_hold  = 0;

    always @(negedge clk) begin
        if (dac_clear) begin
            pif.dac_busy = 1'b0;
            dac_delay    = 0;
            dac_hold     = 0;
        end else if (dac_hold > 0) begin
            dac_hold = dac_hold - 1;
            if (dac_hold == 0) pif.dac_busy = 1'b0;
        end else if (dac_delay > 0) begin
            dac_delay = dac_delay - 1;
            if (dac_delay == 0) begin
                pif.dac_busy = 1'b1;
                dac_hold     = dac_dur;
            end
        end else if (!pif.output_send_n && !dac_never) begin
            dac_delay = 40;
        end
    end

    // Reference model: queue of pushed samples and the last level sent out
    logic [15:0] model_q[$];
    logic [11:0] last_out;
    int          model_underruns;

    function automatic logic [11:0] to_offset(input logic [15:0] s);
        int v;
        v = $signed(s) + 32768;
        return 12'(v / 16);
    endfunction

    task automatic model_slot(output logic [11:0] exp);
        if (model_q.size() > 0) last_out = to_offset(model_q.pop_front());
        else if (model_underruns < 65535) model_underruns++;
        exp = last_out;
    endtask

    task automatic apply_reset();
        rst             = 1'b1;
        enable          = 1'b0;
        pif.input_valid = 1'b0;
        pif.input_sample = 16'h0000;
        dac_clear       = 1'b1;
        dac_never       = 1'b0;
        dac_dur         = 1500;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        dac_clear = 1'b0;
        model_q.delete();
        model_underruns = 0;
        last_out = 12'h800;
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] s);
        pif.input_sample = s;
        pif.input_valid  = 1'b1;
        if (pif.input_ready) model_q.push_back(s);
        @(negedge clk);
        pif.input_valid = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sample_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (pif.output_send_n !== 1'b1 || pif.output_sample !== 12'h800) begin
            n_err++;
            $display("FAIL reset_outputs: send_n=%b sample=%h want send_n=1 sample=800",
                     pif.output_send_n, pif.output_sample);
        end
        n_cmp++;
        if (fifo_level !== 5'd0 || pif.input_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_fifo: level=%0d ready=%b want level=0 ready=1",
                     fifo_level, pif.input_ready);
        end
        n_cmp++;
        if (sample_tick !== 1'b0 || underrun_count !== 16'd0 || late_error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: tick=%b underruns=%0d late=%b want 0/0/0",
                     sample_tick, underrun_count, late_error);
        end
    endtask

    task automatic test_basic_slots();
        logic [15:0] s [4];
        logic [11:0] exp;
        int unsigned t_ref;
        bit ok;
        apply_reset();
        s[0] = 16'h0000;
        s[1] = 16'h7FFF;
        s[2] = 16'($urandom);
        s[3] = 16'($urandom);
        for (int i = 0; i < 4; i++) push(s[i]);
        n_cmp++;
        if (fifo_level !== 5'd4) begin
            n_err++;
            $display("FAIL basic_level: got %0d want 4", fifo_level);
        end
        enable = 1'b1;
        t_ref  = cycle_no;
        for (int i = 0; i < 4; i++) begin
            wait_tick(ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL basic_tick_wait: no tick within bound, slot %0d", i);
            end
            n_cmp++;
            if (cycle_no - t_ref !== ((i == 0) ? SAMPLE_DIVIDE - 1 : SAMPLE_DIVIDE)) begin
                n_err++;
                $display("FAIL basic_tick_gap: slot %0d got %0d cycles want %0d", i,
                         cycle_no - t_ref, (i == 0) ? SAMPLE_DIVIDE - 1 : SAMPLE_DIVIDE);
            end
            t_ref = cycle_no;
            n_cmp++;
            if (pif.output_send_n !== 1'b1) begin
                n_err++;
                $display("FAIL basic_send_n_at_tick: got %b want 1", pif.output_send_n);
            end
            model_slot(exp);
            @(negedge clk);
            n_cmp++;
            if (pif.output_send_n !== 1'b0 || pif.output_sample !== exp) begin
                n_err++;
                $display("FAIL basic_slot: slot %0d send_n=%b sample=%h want send_n=0 sample=%h",
                         i, pif.output_send_n, pif.output_sample, exp);
            end
        end
        n_cmp++;
        if (late_error !== 1'b0) begin
            n_err++;
            $display("FAIL basic_late: got %b want 0", late_error);
        end
    endtask

    task automatic test_underrun();
        logic [11:0] exp;
        bit ok;
        apply_reset();
        push(16'h8000);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tick(ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL underrun_tick_wait: no tick within bound, slot %0d", i);
            end
            model_slot(exp);
            @(negedge clk);
            n_cmp++;
            if (pif.output_send_n !== 1'b0 || pif.output_sample !== exp) begin
                n_err++;
                $display("FAIL underrun_slot: slot %0d send_n=%b sample=%h want send_n=0 sample=%h",
                         i, pif.output_send_n, pif.output_sample, exp);
            end
        end
        n_cmp++;
        if (underrun_count !== 16'(model_underruns)) begin
            n_err++;
            $display("FAIL underrun_count: got %0d want %0d", underrun_count, model_underruns);
        end
    endtask

    // Continues from the underrun scenario so the counters are non-zero
    task automatic test_reset_mid_request();
        logic [11:0] exp;
        bit ok;
        push(16'($urandom));
        push(16'($urandom));
        wait_tick(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL midreset_tick_wait: no tick within bound");
        end
        model_slot(exp);
        @(negedge clk);
        n_cmp++;
        if (pif.output_send_n !== 1'b0 || pif.output_sample !== exp || fifo_level !== 5'd1) begin
            n_err++;
            $display("FAIL midreset_request: send_n=%b sample=%h level=%0d want 0/%h/1",
                     pif.output_send_n, pif.output_sample, fifo_level, exp);
        end
        rst       = 1'b1;
        dac_clear = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pif.output_send_n !== 1'b1 || pif.output_sample !== 12'h800) begin
            n_err++;
            $display("FAIL midreset_outputs: send_n=%b sample=%h want 1/800",
                     pif.output_send_n, pif.output_sample);
        end
        n_cmp++;
        if (fifo_level !== 5'd0 || underrun_count !== 16'd0) begin
            n_err++;
            $display("FAIL midreset_counts: level=%0d underruns=%0d want 0/0",
                     fifo_level, underrun_count);
        end
        rst       = 1'b0;
        dac_clear = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [11:0] exp;
        logic [15:0] s;
        bit exp_ready;
        bit ok;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            s         = 16'($urandom);
            exp_ready = (model_q.size() < 16);
            n_cmp++;
            if (pif.input_ready !== exp_ready) begin
                n_err++;
                $display("FAIL full_ready: push %0d got %b want %b", i, pif.input_ready, exp_ready);
            end
            push(s);
        end
        n_cmp++;
        if (fifo_level !== 5'd16 || pif.input_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_level: level=%0d ready=%b want 16/0", fifo_level, pif.input_ready);
        end
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_tick(ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL full_tick_wait: no tick within bound, slot %0d", i);
            end
            model_slot(exp);
            @(negedge clk);
            n_cmp++;
            if (pif.output_sample !== exp) begin
                n_err++;
                $display("FAIL full_drain_order: slot %0d got %h want %h", i, pif.output_sample, exp);
            end
        end
        n_cmp++;
        if (fifo_level !== 5'd0 || underrun_count !== 16'd0) begin
            n_err++;
            $display("FAIL full_drained: level=%0d underruns=%0d want 0/0", fifo_level, underrun_count);
        end
    endtask

    task automatic test_timeout();
        logic [11:0] exp;
        int n_low;
        bit ok;
        apply_reset();
        dac_never = 1'b1;
        push(16'($urandom));
        push(16'($urandom));
        enable = 1'b1;
        wait_tick(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL timeout_tick_wait: no first tick within bound");
        end
        model_slot(exp);
        n_low = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (pif.output_send_n === 1'b0) n_low++;
            else break;
        end
        n_cmp++;
        if (n_low !== HANDSHAKE_TIMEOUT) begin
            n_err++;
            $display("FAIL timeout_length: send_n low %0d cycles want %0d", n_low, HANDSHAKE_TIMEOUT);
        end
        n_cmp++;
        if (late_error !== 1'b1 || fifo_level !== 5'd1) begin
            n_err++;
            $display("FAIL timeout_status: late=%b level=%0d want 1/1", late_error, fifo_level);
        end
        wait_tick(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL timeout_tick_wait2: no tick after timeout within bound");
        end
        model_slot(exp);
        @(negedge clk);
        n_cmp++;
        if (pif.output_send_n !== 1'b0 || pif.output_sample !== exp) begin
            n_err++;
            $display("FAIL timeout_rerequest: send_n=%b sample=%h want 0/%h",
                     pif.output_send_n, pif.output_sample, exp);
        end
    endtask

    task automatic test_long_busy();
        logic [11:0] exp;
        bit ok;
        apply_reset();
        dac_dur = 3000;
        push(16'($urandom));
        push(16'($urandom));
        enable = 1'b1;
        wait_tick(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL longbusy_tick_wait: no first tick within bound");
        end
        model_slot(exp);
        @(negedge clk);
        wait_tick(ok);
        n_cmp++;
        if (!ok || late_error !== 1'b0) begin
            n_err++;
            $display("FAIL longbusy_before: tick_ok=%b late=%b want 1/0", ok, late_error);
        end
        @(negedge clk);
        n_cmp++;
        if (late_error !== 1'b1 || fifo_level !== 5'd1) begin
            n_err++;
            $display("FAIL longbusy_late: late=%b level=%0d want 1/1", late_error, fifo_level);
        end
        n_cmp++;
        if (pif.output_sample !== exp || pif.output_send_n !== 1'b1) begin
            n_err++;
            $display("FAIL longbusy_hold: sample=%h send_n=%b want %h/1",
                     pif.output_sample, pif.output_send_n, exp);
        end
    endtask

    initial begin
        rst              = 1'b1;
        enable           = 1'b0;
        pif.input_valid  = 1'b0;
        pif.input_sample = 16'h0000;
        @(negedge clk);
        test_reset();
        test_basic_slots();
        test_underrun();
        test_reset_mid_request();
        test_fifo_full();
        test_timeout();
        test_long_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dac_sample_pacer.md
Name: dac_sample_pacer

Overview:
Upstream feeder for the SPI DAC output controller. Buffers signed 16-bit audio samples from the synth/mixer in a small FIFO and releases exactly one sample per 22050 Hz output slot. Converts each sample to 12-bit offset-binary and drives the DAC controller's active-low send request, handshaking on its busy flag. Runs entirely in the 50 MHz domain; the DAC controller's busy flag is treated as asynchronous.

Parameters:
SAMPLE_DIVIDE, 2268, clock_50Mhz cycles per output slot (50e6/22050, rounded).
FIFO_ADDR_BITS, 4, FIFO depth = 2**FIFO_ADDR_BITS = 16 entries.
HANDSHAKE_TIMEOUT, 4096, cycles REQUEST waits for busy before abandoning.

Ports:
clock_50Mhz  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-high reset.
enable  in  1  1 = pacing runs; 0 = slot counter held at 0, no ticks.
input_sample  in  16  signed two's-complement sample from mixer.
input_valid  in  1  push request.
input_ready  out  1  = !fifo_full; push accepted when input_valid && input_ready.
output_sample  out  12  to DAC controller inputSample; stable while request outstanding.
output_send_n  out  1  to DAC controller sendSample_n; active low.
dac_busy  in  1  DAC controller isBusy; asynchronous, 2-flop synchronised internally (busy_s).
fifo_level  out  FIFO_ADDR_BITS+1  current occupancy, 0..16.
sample_tick  out  1  one-cycle pulse at each slot boundary.
underrun_count  out  16  slots with empty FIFO; saturates at 16'hFFFF.
late_error  out  1  sticky; slot tick arrived while not IDLE or while busy_s high.

Behaviour:
- Reset (sync, active-high): slot counter 0, FIFO empty, fifo_level 0, input_ready 1, output_send_n 1, output_sample 12'h800 (midscale), sample_tick 0, underrun_count 0, late_error 0, FSM IDLE, sync flops 0.
- Slot counter: when enable, counts 0..SAMPLE_DIVIDE-1 and wraps. sample_tick=1 in the cycle the counter equals SAMPLE_DIVIDE-1. When enable=0, counter is 0 and no ticks.
- FIFO: synchronous, first-word fall-through not required. Push when input_valid && input_ready. Pop only from FSM. Simultaneous push+pop when not full and not empty: level unchanged. When full, input_ready=0 and push is ignored even if a pop occurs in the same cycle. Pointers wrap modulo depth.
- Conversion at pop: output_sample = {~s[15], s[14:4]} (truncate 4 LSBs, invert MSB). Examples: 16'h0000 -> 12'h800; 16'h7FFF -> 12'hFFF; 16'h8000 -> 12'h000; 16'hFFF0 -> 12'h7FF.
- FSM:
  IDLE: on sample_tick:
    - if busy_s=1: set late_error, stay IDLE.
    - else if FIFO non-empty: pop, register the converted output_sample, set output_send_n=0 next cycle, go REQUEST.
    - else (underrun): underrun_count+1 (saturating), keep the previous output_sample, set output_send_n=0, go REQUEST. This repeats the last level.
  REQUEST: output_send_n held 0.
    - busy_s=1: output_send_n=1, go WAIT_DONE.
    - If HANDSHAKE_TIMEOUT cycles pass without busy_s: output_send_n=1, set late_error, go IDLE.
  WAIT_DONE: output_send_n=1. When busy_s=0, go IDLE.
- sample_tick in REQUEST or WAIT_DONE: set late_error. No pop and no counter change; the slot is lost.
- Latency: tick -> output_send_n low = 1 cycle. output_sample changes only on the IDLE->REQUEST transition.
- Reset mid-handshake: output_send_n returns to 1 the cycle after reset asserts. The DAC controller may still be busy; the first tick after reset with busy_s=1 sets late_error, per the IDLE rule.
- late_error clears only on reset.

Test Plan:
- Reset, then push 16'h0000 and 16'h7FFF with enable=1 and a DAC model (busy rises 40 cycles after send_n low, lasts 1500 cycles). Required: first tick gives output_sample 12'h800 and send_n low exactly 1 cycle after tick; next tick gives 12'hFFF; ticks are 2268 cycles apart.
- Empty FIFO for 3 ticks after one sample 16'h8000 -> output_sample stays 12'h000; underrun_count=3; send_n pulses each slot.
- Push 20 samples back-to-back with enable=0 -> input_ready drops after the 16th accept; fifo_level=16; samples 17-20 are not stored; drain order matches push order.
- DAC model never asserts busy -> send_n low for 4096 cycles, then high; late_error=1; FSM back in IDLE; next tick issues a new request.
- DAC busy held 3000 cycles (longer than a slot) -> the tick during WAIT_DONE sets late_error; that tick pops nothing; fifo_level is unchanged.
- Assert reset while in REQUEST -> next cycle output_send_n=1, output_sample=12'h800, fifo_level=0, underrun_count=0.
